// File: rtl/calc_sequencer.sv
// calc_sequencer: command-stream FSM sequencing the arithmetic unit loads, settle wait and result handshake
module calc_sequencer #(
    parameter int N             = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int CW            = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_type_i,
    input  logic [N-1:0] cmd_data_i,
    output logic [N-1:0] au_in_o,
    output logic         au_loadA_o,
    output logic         au_loadB_o,
    output logic         au_loadR_o,
    output logic [2:0]   au_op_o,
    output logic         au_reset_o,
    input  logic [N-1:0] au_result_i,
    output logic [N-1:0] res_data_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         busy_o,
    output logic         err_o
);
    typedef enum logic [3:0] {
        IDLE_A, LOADA, WAIT_OP, WAIT_B, LOADB, SETTLE, CAPTURE, PRESENT, CHAIN, CLEAR
    } state_t;
    localparam logic [1:0] T_OPND = 2'b00, T_OPER = 2'b01, T_CLR = 2'b10;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   au_in_q, au_in_d, res_data_q, res_data_d;
    logic [2:0]     au_op_q, au_op_d;
    logic           err_q, err_d, acc;
    logic           ready_q, load_a_q, load_b_q, load_r_q, au_reset_q, res_valid_q, busy_q;
    // next state and next datapath-facing register values; strobes decode the next state so they leave flops
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        au_in_d    = au_in_q;
        au_op_d    = au_op_q;
        res_data_d = res_data_q;
        err_d      = 1'b0;
        acc        = cmd_valid_i & ready_q;
        case (state_q)
            IDLE_A: if (acc) begin
                if (cmd_type_i == T_OPND) begin
                    au_in_d = cmd_data_i;
                    state_d = LOADA;
                end else if (cmd_type_i == T_CLR) state_d = CLEAR;
                else err_d = 1'b1;
            end
            LOADA: state_d = WAIT_OP;
            WAIT_OP: if (acc) begin
                if (cmd_type_i == T_OPND) begin
                    au_in_d = cmd_data_i;
                    state_d = LOADA;
                end else if (cmd_type_i == T_OPER) begin
                    au_op_d = cmd_data_i[2:0];
                    state_d = WAIT_B;
                end else if (cmd_type_i == T_CLR) state_d = CLEAR;
                else err_d = 1'b1;
            end
            WAIT_B: if (acc) begin
                if (cmd_type_i == T_OPND) begin
                    au_in_d = cmd_data_i;
                    state_d = LOADB;
                end else if (cmd_type_i == T_OPER) au_op_d = cmd_data_i[2:0];
                else if (cmd_type_i == T_CLR) state_d = CLEAR;
                else err_d = 1'b1;
            end
            LOADB: begin
                cnt_d   = CW'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? CAPTURE : SETTLE;
            end
            CAPTURE: begin
                res_data_d = au_result_i;
                state_d    = PRESENT;
            end
            PRESENT: if (res_ready_i) begin
                au_in_d = res_data_q;
                state_d = CHAIN;
            end
            CHAIN: state_d = WAIT_OP;
            CLEAR: state_d = IDLE_A;
            default: state_d = IDLE_A;
        endcase
        au_op_d    = (state_d == CLEAR) ? 3'd0 : au_op_d;
        res_data_d = (state_d == CLEAR) ? '0 : res_data_d;
    end
    // state, datapath registers and registered output strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE_A;
            cnt_q       <= '0;
            au_in_q     <= '0;
            au_op_q     <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            load_r_q    <= 1'b0;
            au_reset_q  <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            au_in_q     <= au_in_d;
            au_op_q     <= au_op_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            ready_q     <= state_d inside {IDLE_A, WAIT_OP, WAIT_B};
            load_a_q    <= state_d inside {LOADA, CHAIN};
            load_b_q    <= state_d == LOADB;
            load_r_q    <= state_d == CAPTURE;
            au_reset_q  <= state_d == CLEAR;
            res_valid_q <= state_d == PRESENT;
            busy_q      <= state_d inside {LOADB, SETTLE, CAPTURE, PRESENT, CHAIN};
        end
    end
    assign cmd_ready_o = ready_q;
    assign au_in_o     = au_in_q;
    assign au_loadA_o  = load_a_q;
    assign au_loadB_o  = load_b_q;
    assign au_loadR_o  = load_r_q;
    assign au_op_o     = au_op_q;
    assign au_reset_o  = au_reset_q;
    assign res_data_o  = res_data_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench with a token-level calculator model and a per-cycle compare process
module tb_calc_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, res_ready = 1'b0;
    logic [1:0]  cmd_type = 2'b00;
    logic [31:0] cmd_data = '0, au_in, au_result, res_data;
    logic        load_a, load_b, load_r, au_reset, res_valid, busy, err;
    logic [2:0]  au_op;
    logic [31:0] ra, rb;
    logic [31:0] mdl_a = '0, mdl_b = '0;
    logic [2:0]  mdl_op = '0;
    int          phase = 0;
    logic [31:0] exp_q[$];
    int          n_chk = 0, n_fail = 0;
    int          n_a = 0, n_b = 0, n_r = 0;
    int          err_req = 0, err_ack = 0;
    int          cyc, a0, b0, r0;

    calc_sequencer dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_type_i(cmd_type), .cmd_data_i(cmd_data), .au_in_o(au_in),
        .au_loadA_o(load_a), .au_loadB_o(load_b), .au_loadR_o(load_r), .au_op_o(au_op),
        .au_reset_o(au_reset), .au_result_i(au_result), .res_data_o(res_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return a;
        endcase
    endfunction

    // arithmetic unit stand-in: A/B registers on the strobes, combinational result
    always @(posedge clk or posedge rst) begin
        if (rst || au_reset) begin
            ra <= '0;
            rb <= '0;
        end else begin
            if (load_a) ra <= au_in;
            if (load_b) rb <= au_in;
        end
    end
    assign au_result = alu(ra, rb, au_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // per-cycle comparison against the token-level model
    always @(negedge clk) begin
        if (load_a) n_a++;
        if (load_b) n_b++;
        if (load_r) n_r++;
        if (rst) err_ack = err_req;
        else begin
            chk("strobe_onehot", 32'(int'(load_a) + int'(load_b) + int'(load_r) <= 1), 1);
            chk("busy_ready_excl", 32'(busy & cmd_ready), 0);
            chk("err_pulse", err, err_req != err_ack);
            err_ack = err_req;
            chk("au_op", au_op, mdl_op);
            if (load_a) chk("loadA_value", au_in, mdl_a);
            if (load_b) chk("loadB_value", au_in, mdl_b);
            if (res_valid) chk("res_scoreboard", res_data, exp_q.size() > 0 ? exp_q[0] : ~res_data);
        end
    end

    task automatic send(input logic [1:0] t, input logic [31:0] d);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        case (t)
            2'b00: if (phase == 2) begin
                exp_q.push_back(alu(mdl_a, d, mdl_op));
                mdl_b = d;
                phase = 3;
            end else begin
                mdl_a = d;
                phase = 1;
            end
            2'b01: if (phase == 0) err_req++;
            else begin
                mdl_op = d[2:0];
                phase  = 2;
            end
            2'b10: begin
                phase  = 0;
                mdl_op = 3'd0;
                exp_q.delete();
            end
            default: err_req++;
        endcase
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (c < 50) begin
            @(negedge clk);
            c++;
            if (res_valid) break;
        end
        if (!res_valid) chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic take();
        int w = 0;
        @(negedge clk);
        res_ready = 1'b1;
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!res_valid) chk("res_take_timeout", res_valid, 1);
        @(posedge clk);
        if (exp_q.size() > 0) mdl_a = exp_q.pop_front();
        phase = 1;
        #1 res_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_au_reset", au_reset, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_au_in", au_in, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_au_op", au_op, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_au_reset", au_reset, 0);
        chk("rel_cmd_ready", cmd_ready, 1);
        send(2'b00, 7);
        send(2'b01, 0);
        send(2'b00, 5);
        wait_valid(cyc);
        chk("latency_B_to_valid", cyc, 7);
        chk("first_res_data", res_data, 12);
        chk("one_loadA", n_a, 1);
        chk("one_loadB", n_b, 1);
        chk("one_loadR", n_r, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 12);
            chk("hold_ready_low", cmd_ready, 0);
            chk("hold_busy", busy, 1);
        end
        take();
        @(negedge clk);
        chk("chain_loadA", load_a, 1);
        chk("chain_au_in", au_in, 12);
        send(2'b01, 2);
        send(2'b00, 3);
        wait_valid(cyc);
        chk("chain_res_data", res_data, 36);
        take();
        send(2'b10, 0);
        a0 = n_a;
        send(2'b01, 1);
        @(negedge clk);
        chk("idle_oper_err", err, 1);
        @(negedge clk);
        chk("idle_oper_err_end", err, 0);
        chk("idle_oper_no_load", n_a, a0);
        chk("idle_oper_ready", cmd_ready, 1);
        send(2'b00, 9);
        send(2'b01, 1);
        b0 = n_b;
        send(2'b11, 0);
        @(negedge clk);
        chk("rsv_err", err, 1);
        @(negedge clk);
        chk("rsv_err_end", err, 0);
        chk("rsv_no_loadB", n_b, b0);
        chk("rsv_ready", cmd_ready, 1);
        send(2'b10, 0);
        @(negedge clk);
        chk("clr_au_reset", au_reset, 1);
        chk("clr_au_op", au_op, 0);
        @(negedge clk);
        chk("clr_au_reset_end", au_reset, 0);
        a0 = n_a;
        b0 = n_b;
        send(2'b00, 4);
        repeat (2) @(negedge clk);
        chk("clr_next_is_A", n_a, a0 + 1);
        chk("clr_next_not_B", n_b, b0);
        send(2'b01, 0);
        send(2'b00, 6);
        wait_valid(cyc);
        chk("post_clr_res", res_data, 10);
        take();
        send(2'b00, 20);
        send(2'b01, 1);
        send(2'b00, 8);
        repeat (3) @(negedge clk);
        r0 = n_r;
        rst = 1'b1;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_au_reset", au_reset, 1);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_au_in", au_in, 0);
        chk("abort_au_op", au_op, 0);
        phase  = 0;
        mdl_op = 3'd0;
        mdl_a  = '0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("abort_no_loadR", n_r, r0);
        chk("abort_au_reset_held", au_reset, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rel_au_reset", au_reset, 0);
        chk("abort_rel_ready", cmd_ready, 1);
        chk("abort_rel_no_loadR", n_r, r0);
        send(2'b00, 100);
        send(2'b01, 1);
        send(2'b00, 58);
        wait_valid(cyc);
        chk("sub_res", res_data, 42);
        take();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM that drives the arithmetic unit (operand registers A/B, opcode, result register) from a single command stream.
- Accepts operand/operator/clear tokens over a valid/ready handshake.
- Pulses the A/B/R load strobes in order and waits a fixed settle time for the combinational datapath (divider worst case).
- Presents the result over a valid/ready handshake, then chains it back into A for running calculations.

Parameters:
N, 32, datapath width (matches arithmetic unit N)
SETTLE_CYCLES, 4, cycles waited after LoadB before LoadR; legal range 1..255
CW, 8, settle counter width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_type  in  2  00 operand, 01 operator, 10 clear, 11 reserved
cmd_data  in  N  operand value; operator uses cmd_data[2:0] as opcode
au_in  out  N  data to arithmetic unit input bus
au_loadA  out  1  load strobe, register A
au_loadB  out  1  load strobe, register B
au_loadR  out  1  load strobe, register R
au_op  out  3  opcode to arithmetic unit
au_reset  out  1  clear to arithmetic unit registers
au_result  in  N  arithmetic unit combinational result
res_data  out  N  captured result
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
busy  out  1  high in LOADB, SETTLE, CAPTURE, PRESENT, CHAIN
err  out  1  one-cycle pulse on protocol error

Behaviour:
- All outputs are registered. Async Reset forces:
  - state IDLE_A; au_reset=1; all other outputs 0; au_in, au_op, res_data = 0.
  - au_reset drops on the first Clock edge after Reset deasserts.
- cmd_ready = 1 only in IDLE_A, WAIT_OP, WAIT_B.
- Each load strobe is high for exactly one cycle. au_in is stable in the strobe cycle and held afterwards. au_op holds the last accepted opcode.
- IDLE_A:
  - operand -> au_in<=data, go LOADA.
  - operator or reserved -> consumed, ignored, err pulse.
  - clear -> CLEAR.
- LOADA: au_loadA=1 -> WAIT_OP.
- WAIT_OP:
  - operator -> au_op<=data[2:0], go WAIT_B.
  - operand -> replaces A (au_in<=data, go LOADA); this starts a new calculation, no error.
  - clear -> CLEAR.
  - reserved -> err pulse, stay.
- WAIT_B:
  - operand -> au_in<=data, go LOADB.
  - operator -> replaces au_op, stay, no error.
  - clear -> CLEAR.
  - reserved -> err pulse, stay.
- LOADB: au_loadB=1; counter<=SETTLE_CYCLES-1 -> SETTLE.
- SETTLE:
  - decrement counter each cycle; exactly SETTLE_CYCLES cycles in this state.
  - at 0 -> CAPTURE.
- CAPTURE: au_loadR=1; res_data<=au_result -> PRESENT.
- PRESENT:
  - res_valid=1; res_data held stable until res_valid & res_ready.
  - on handshake: res_valid<=0, au_in<=res_data -> CHAIN.
- CHAIN: au_loadA=1 (result becomes A) -> WAIT_OP.
- CLEAR:
  - au_reset=1 for one cycle; au_op<=0; res_data<=0 -> IDLE_A.
  - A pending result is discarded.
- Latency:
  - operand B accepted at edge k -> res_valid first high in cycle k+SETTLE_CYCLES+3.
  - With default 4, that is 7 cycles after the accept edge.
- err is asserted in the cycle after the offending accept.
- Arithmetic semantics (overflow, divide by zero) belong to the datapath; the sequencer passes values unchanged. res_data is always exactly au_result at CAPTURE.
- Async Reset mid-operation, in any state, aborts immediately to reset values. No strobe may glitch; strobes come from registered state only.
- res_ready high outside PRESENT is ignored.
- cmd_valid with cmd_ready low is not consumed and must be held by the source.

Test Plan:
- Reset, then operand 7, operator ADD (000), operand 5 -> one pulse each on au_loadA, au_loadB, au_loadR.
  - res_valid rises 7 cycles after the B accept edge.
  - res_data=12.
- Continue from that result: res_ready, then operator MUL, operand 3 -> au_loadA pulses in CHAIN with au_in=12; next result 36.
- Hold res_ready=0 for 10 cycles in PRESENT -> res_valid and res_data held constant; cmd_ready=0 throughout; busy=1.
- Operator in IDLE_A, and reserved type in WAIT_B -> each consumed; one-cycle err pulse; state unchanged; no load strobes.
- Clear accepted in WAIT_B after A=9 -> au_reset pulse for one cycle; au_op=0; next operand is loaded as A, not B.
- Assert Reset during SETTLE (2 cycles in) -> state, outputs, res_valid reset immediately.
  - au_loadR never pulses.
  - au_reset=1 until the first edge after release.
